text_buffer_arbiter: RTL and testbench

Owns the single-port 64x32 character RAM that backs the text-mode VGA display. It shares that RAM between three requesters, in fixed priority order:
- the display character fetch;
- a bulk clear engine;
- a small write FIFO fed by the CPU io path.

It sits between the io write port and the pixel/glyph pipeline, entirely in the VGA_CLK domain.

---
 rtl/text_buffer_arbiter.sv | 173 +++++++++++++++++
 tb/tb_text_buffer_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter
//   Shares the single-port text-mode character RAM between three requesters in fixed
//   priority: display fetch, bulk clear engine, CPU write FIFO. All logic on VGA_CLK.
// Ports:
//   VGA_CLK, reset (async, active-low)
//   disp_req/disp_addr -> disp_valid/disp_data   display fetch, one-cycle read latency
//   wr_valid/wr_ready/wr_addr/wr_data            CPU write FIFO push side
//   clr_start/clr_char -> clr_busy               fill whole buffer with clr_char
//   mem_addr/mem_we/mem_wdata/mem_rdata          RAM port (RAM registers its address)
module text_buffer_arbiter #(
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = $clog2(COLS * ROWS)
) (
  input  logic          VGA_CLK,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [7:0]    disp_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clr_start,
  input  logic [7:0]    clr_char,
  output logic          clr_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] LastAddr = AW'(COLS * ROWS - 1);

  typedef enum logic [1:0] {StIdle, StPending, StClearing} clr_state_e;

  clr_state_e    clr_state_q, clr_state_d;
  logic [7:0]    clr_char_q, clr_char_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [7:0]    fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [7:0]    last_wdata_q, last_wdata_d;
  logic          disp_valid_q;
  logic [7:0]    disp_data_q, disp_data_d;

  logic fifo_empty, fifo_full, push, clr_grant, fifo_grant;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  // Display always wins; the clear blocks the FIFO only once it is actually clearing.
  assign clr_grant  = !disp_req && (clr_state_q == StClearing);
  assign fifo_grant = !disp_req && (clr_state_q != StClearing) && !fifo_empty;

  // Clear FSM: state register
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      clr_state_q <= StIdle;
      clr_char_q  <= '0;
      clr_cnt_q   <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_char_q  <= clr_char_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  // Clear FSM: next state
  always_comb begin
    clr_state_d = clr_state_q;
    clr_char_d  = clr_char_q;
    clr_cnt_d   = clr_cnt_q;
    unique case (clr_state_q)
      StIdle: begin
        if (clr_start) begin
          clr_state_d = StPending;
          clr_char_d  = clr_char;
        end
      end
      // Wait for writes accepted before clr_start to land first.
      StPending: begin
        if (fifo_empty) clr_state_d = StClearing;
      end
      StClearing: begin
        if (clr_grant) begin
          clr_cnt_d = clr_cnt_q + AW'(1);  // wraps to 0 after the last address
          if (clr_cnt_q == LastAddr) clr_state_d = StIdle;
        end
      end
      default: clr_state_d = StIdle;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    clr_busy = (clr_state_q != StIdle);
    wr_ready = !fifo_full && (clr_state_q == StIdle);
  end

  // RAM port arbitration; address and data hold their last value when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = last_addr_q;
    mem_wdata = last_wdata_q;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (clr_grant) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt_q;
      mem_wdata = clr_char_q;
    end else if (fifo_grant) begin
      mem_we    = 1'b1;
      mem_addr  = fifo_addr_q[rd_ptr_q];
      mem_wdata = fifo_data_q[rd_ptr_q];
    end
    last_addr_d  = mem_addr;
    last_wdata_d = mem_wdata;
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_grant ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !fifo_grant) count_d = count_q + CW'(1);
    else if (!push && fifo_grant) count_d = count_q - CW'(1);
  end

  // Display return path: disp_data follows the RAM while valid, then holds.
  always_comb begin
    disp_data_d = disp_valid_q ? mem_rdata : disp_data_q;
    disp_valid  = disp_valid_q;
    disp_data   = disp_data_d;
  end

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
      disp_valid_q <= disp_req;
      disp_data_q  <= disp_data_d;
    end
  end

  // FIFO storage needs no reset; occupancy guards every read.
  always_ff @(posedge VGA_CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed testbench for text_buffer_arbiter with a behavioural 2048x8 RAM that
// registers its read address.
module tb_text_buffer_arbiter;

  localparam int AW = 11;
  localparam int NWORDS = 2048;

  logic          VGA_CLK;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [7:0]    disp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          clr_start;
  logic [7:0]    clr_char;
  logic          clr_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  int checks = 0;
  int passes = 0;

  text_buffer_arbiter dut (
    .VGA_CLK   (VGA_CLK),
    .reset     (reset),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_valid(disp_valid),
    .disp_data (disp_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_char  (clr_char),
    .clr_busy  (clr_busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    VGA_CLK = 1'b0;
    forever #5 VGA_CLK = ~VGA_CLK;
  end

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  // RAM model: preloaded with pat() on the first edge, read-first, registered address.
  logic [7:0] ram [NWORDS];
  bit ram_init_done;
  always @(posedge VGA_CLK) begin
    if (!ram_init_done) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= pat(i);
      ram_init_done <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic next_cycle();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req  = 1'b0;
    disp_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clr_start = 1'b0;
    clr_char  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #12;
    checks++; if (disp_valid !== 1'b0) $display("FAIL rst_disp_valid got %b want 0", disp_valid); else passes++;
    checks++; if (disp_data !== 8'h00) $display("FAIL rst_disp_data got %h want 00", disp_data); else passes++;
    checks++; if (clr_busy !== 1'b0) $display("FAIL rst_clr_busy got %b want 0", clr_busy); else passes++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b want 0", mem_we); else passes++;
    checks++; if (mem_addr !== 11'd0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passes++;
    checks++; if (mem_wdata !== 8'h00) $display("FAIL rst_mem_wdata got %h want 00", mem_wdata); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready got %b want 1", wr_ready); else passes++;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_clear();
    bit found = 0;
    next_cycle();
    clr_start = 1'b1;
    clr_char  = 8'h20;
    next_cycle();
    clr_start = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      #1;
      if (mem_we && mem_addr == 11'd100) found = 1;
      else next_cycle();
    end
    checks++; if (!found) $display("FAIL rmc_reach_100 got timeout want write to 100"); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (disp_valid !== 1'b0) $display("FAIL rmc_disp_valid got %b want 0", disp_valid); else passes++;
    checks++; if (clr_busy !== 1'b0) $display("FAIL rmc_clr_busy got %b want 0", clr_busy); else passes++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rmc_mem_we got %b want 0", mem_we); else passes++;
    checks++; if (mem_addr !== 11'd0) $display("FAIL rmc_mem_addr got %h want 0", mem_addr); else passes++;
    checks++; if (mem_wdata !== 8'h00) $display("FAIL rmc_mem_wdata got %h want 00", mem_wdata); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL rmc_wr_ready got %b want 1", wr_ready); else passes++;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    #1;
    checks++; if (clr_busy !== 1'b0) $display("FAIL rmc_post_busy got %b want 0", clr_busy); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL rmc_post_ready got %b want 1", wr_ready); else passes++;
    checks++; if (ram[99] !== 8'h20) $display("FAIL rmc_ram99 got %h want 20", ram[99]); else passes++;
    checks++; if (ram[150] !== pat(150)) $display("FAIL rmc_ram150 got %h want %h", ram[150], pat(150)); else passes++;
  endtask

  task automatic test_display_priority();
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      disp_req  = 1'b1;
      disp_addr = AW'(32'h300 + k);
      wr_valid  = (k < 3);
      wr_addr   = AW'(32'h100 + k);
      wr_data   = 8'(32'h41 + k);
      #1;
      checks++; if (mem_we !== 1'b0) $display("FAIL dp_no_we[%0d] got %b want 0", k, mem_we); else passes++;
      checks++; if (mem_addr !== disp_addr) $display("FAIL dp_addr[%0d] got %h want %h", k, mem_addr, disp_addr); else passes++;
      if (k > 0) begin
        checks++; if (disp_valid !== 1'b1) $display("FAIL dp_valid[%0d] got %b want 1", k, disp_valid); else passes++;
        checks++; if (disp_data !== pat(32'h300 + k - 1)) $display("FAIL dp_data[%0d] got %h want %h", k, disp_data, pat(32'h300 + k - 1)); else passes++;
      end else begin
        checks++; if (disp_valid !== 1'b0) $display("FAIL dp_valid0 got %b want 0", disp_valid); else passes++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      disp_req = 1'b0;
      wr_valid = 1'b0;
      #1;
      if (j < 3) begin
        checks++; if (mem_we !== 1'b1) $display("FAIL dp_drain_we[%0d] got %b want 1", j, mem_we); else passes++;
        checks++; if (mem_addr !== AW'(32'h100 + j)) $display("FAIL dp_drain_addr[%0d] got %h want %h", j, mem_addr, 32'h100 + j); else passes++;
        checks++; if (mem_wdata !== 8'(32'h41 + j)) $display("FAIL dp_drain_data[%0d] got %h want %h", j, mem_wdata, 32'h41 + j); else passes++;
      end else begin
        checks++; if (mem_we !== 1'b0) $display("FAIL dp_idle_we[%0d] got %b want 0", j, mem_we); else passes++;
        checks++; if (mem_addr !== 11'h102) $display("FAIL dp_idle_addr[%0d] got %h want 102", j, mem_addr); else passes++;
      end
      if (j == 0) begin
        checks++; if (disp_valid !== 1'b1) $display("FAIL dp_last_valid got %b want 1", disp_valid); else passes++;
      end
      if (j == 1) begin
        checks++; if (disp_valid !== 1'b0) $display("FAIL dp_valid_drop got %b want 0", disp_valid); else passes++;
        checks++; if (disp_data !== pat(32'h309)) $display("FAIL dp_data_hold got %h want %h", disp_data, pat(32'h309)); else passes++;
      end
    end
  endtask

  task automatic test_fifo_full();
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      disp_req  = 1'b1;
      disp_addr = 11'h310;
      wr_valid  = 1'b1;
      wr_addr   = (k < 4) ? AW'(32'h200 + k) : 11'h2FF;
      wr_data   = (k < 4) ? 8'(32'h61 + k) : 8'hEE;
      #1;
      checks++; if (wr_ready !== (k < 4)) $display("FAIL ff_ready[%0d] got %b want %b", k, wr_ready, k < 4); else passes++;
    end
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      disp_req = 1'b0;
      wr_valid = 1'b0;
      #1;
      if (j < 4) begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== AW'(32'h200 + j) || mem_wdata !== 8'(32'h61 + j))
          $display("FAIL ff_order[%0d] got we=%b %h/%h want 1 %h/%h", j, mem_we, mem_addr, mem_wdata, 32'h200 + j, 32'h61 + j);
        else passes++;
      end else begin
        checks++; if (mem_we !== 1'b0) $display("FAIL ff_extra_write got %b want 0", mem_we); else passes++;
      end
      if (j < 2) begin
        checks++; if (wr_ready !== (j == 1)) $display("FAIL ff_ready_pop[%0d] got %b want %b", j, wr_ready, j == 1); else passes++;
      end
    end
    checks++; if (ram[11'h2FF] !== pat(32'h2FF)) $display("FAIL ff_ignored got %h want %h", ram[11'h2FF], pat(32'h2FF)); else passes++;
  endtask

  task automatic test_clear_order();
    int nw = 0;
    int seq_err = 0;
    int rdy_err = 0;
    int bad = 0;
    int last_we = -1;
    int drop = -1;
    bit first_err = 0;
    next_cycle();
    wr_valid  = 1'b1;
    wr_addr   = 11'h005;
    wr_data   = 8'h41;
    clr_start = 1'b1;
    clr_char  = 8'h20;
    #1;
    checks++; if (wr_ready !== 1'b1) $display("FAIL co_push_ready got %b want 1", wr_ready); else passes++;
    for (int c = 1; c < 3000 && drop < 0; c++) begin
      next_cycle();
      idle_inputs();
      #1;
      if (!clr_busy) drop = c;
      else begin
        if (wr_ready !== 1'b0) rdy_err++;
        if (mem_we) begin
          if (nw == 0) begin
            if (mem_addr !== 11'h005 || mem_wdata !== 8'h41) first_err = 1;
          end else if (mem_addr !== AW'(nw - 1) || mem_wdata !== 8'h20) seq_err++;
          nw++;
          last_we = c;
        end
      end
    end
    checks++; if (first_err) $display("FAIL co_first got other want 005/41"); else passes++;
    checks++; if (seq_err != 0) $display("FAIL co_seq got %0d errors want 0", seq_err); else passes++;
    checks++; if (nw != NWORDS + 1) $display("FAIL co_count got %0d want %0d", nw, NWORDS + 1); else passes++;
    checks++; if (drop != last_we + 1) $display("FAIL co_busy_drop got %0d want %0d", drop, last_we + 1); else passes++;
    checks++; if (rdy_err != 0) $display("FAIL co_ready_busy got %0d want 0", rdy_err); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL co_ready_after got %b want 1", wr_ready); else passes++;
    for (int i = 0; i < NWORDS; i++) if (ram[i] !== 8'h20) bad++;
    checks++; if (bad != 0) $display("FAIL co_ram_fill got %0d bad want 0", bad); else passes++;
  endtask

  task automatic test_clear_interleave();
    int nexp = 0;
    int err = 0;
    int busy = 0;
    int dgrants = 0;
    bit done = 0;
    next_cycle();
    clr_start = 1'b1;
    clr_char  = 8'h2E;
    for (int c = 1; c < 3000 && !done; c++) begin
      next_cycle();
      idle_inputs();
      disp_req  = (c % 8 == 0);
      disp_addr = AW'(32'h300 + c % 16);
      #1;
      if (!clr_busy) done = 1;
      else begin
        busy++;
        if (c > 1 && disp_req) dgrants++;
        if (mem_we) begin
          if (disp_req || mem_addr !== AW'(nexp) || mem_wdata !== 8'h2E) err++;
          nexp++;
        end
      end
    end
    idle_inputs();
    checks++; if (!done) $display("FAIL ci_timeout got busy want idle"); else passes++;
    checks++; if (nexp != NWORDS) $display("FAIL ci_count got %0d want %0d", nexp, NWORDS); else passes++;
    checks++; if (err != 0) $display("FAIL ci_seq got %0d errors want 0", err); else passes++;
    checks++; if (busy != 1 + NWORDS + dgrants) $display("FAIL ci_duration got %0d want %0d", busy, 1 + NWORDS + dgrants); else passes++;
  endtask

  task automatic test_redundant_start();
    int nexp = 0;
    int err = 0;
    bit done = 0;
    next_cycle();
    clr_start = 1'b1;
    clr_char  = 8'h11;
    for (int c = 1; c < 3000 && !done; c++) begin
      next_cycle();
      idle_inputs();
      clr_start = (c == 60);
      clr_char  = (c == 60) ? 8'h77 : 8'h00;
      #1;
      if (!clr_busy) done = 1;
      else if (mem_we) begin
        if (mem_addr !== AW'(nexp) || mem_wdata !== 8'h11) err++;
        nexp++;
      end
    end
    idle_inputs();
    checks++; if (!done) $display("FAIL rs_timeout got busy want idle"); else passes++;
    checks++; if (nexp != NWORDS) $display("FAIL rs_count got %0d want %0d", nexp, NWORDS); else passes++;
    checks++; if (err != 0) $display("FAIL rs_seq got %0d errors want 0", err); else passes++;
    checks++; if (ram[2047] !== 8'h11) $display("FAIL rs_ram_last got %h want 11", ram[2047]); else passes++;
    next_cycle();
    #1;
    checks++; if (clr_busy !== 1'b0) $display("FAIL rs_no_restart got %b want 0", clr_busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_clear();
    test_display_priority();
    test_fifo_full();
    test_clear_order();
    test_clear_interleave();
    test_redundant_start();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
